// File: rtl/inv_rounds_if.sv
// Start/result interface of the AES-128 inverse-round engine.
// The 128-bit buses are [0:127] with byte 0 in [0:7], column-major (bytes 0-3 form column 0).
interface inv_rounds_if;
  logic         enableRounds;
  logic         initialRound;
  logic         finalRound;
  logic [0:127] messageIn;
  logic [0:127] newKey;
  logic [0:127] messageOut;
  logic         roundsDone;
  logic         busy;

  modport master (
    output enableRounds, initialRound, finalRound, messageIn, newKey,
    input  messageOut, roundsDone, busy
  );

  modport slave (
    input  enableRounds, initialRound, finalRound, messageIn, newKey,
    output messageOut, roundsDone, busy
  );
endinterface

// File: rtl/inv_rounds.sv
// Iterative AES-128 inverse round: initial (ARK), middle (ISR,ISB,ARK,IMC), final (ISR,ISB,ARK).
// Define INV_ROUNDS_FUSED_EN to merge ISR and ISB into one ISB_SR state, which saves one cycle.
module inv_rounds (
  input  logic         clk,
  input  logic         rst,
  inv_rounds_if.slave  bus
);

`ifdef INV_ROUNDS_FUSED_EN
  typedef enum logic [2:0] {IDLE, ISB_SR, ARK, IMC, DONE} state_e;
`else
  typedef enum logic [2:0] {IDLE, ISR, ISB, ARK, IMC, DONE} state_e;
`endif

  localparam logic [0:2047] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [0:127] inv_shift_rows(input logic [0:127] s);
    logic [0:127] res;
    // Row r rotates right by r: the byte landing in column c came from column c-r.
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        res[8*(4*c+r) +: 8] = s[8*(4*((c+4-r)%4)+r) +: 8];
    return res;
  endfunction

  function automatic logic [0:127] inv_sub_bytes(input logic [0:127] s);
    logic [0:127] res;
    for (int i = 0; i < 16; i++)
      res[8*i +: 8] = INV_SBOX[{s[8*i +: 8], 3'b000} +: 8];
    return res;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [0:31] inv_mix_col(input logic [0:31] col);
    logic [7:0] a   [4];
    logic [7:0] m9  [4];
    logic [7:0] mb  [4];
    logic [7:0] md  [4];
    logic [7:0] me  [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[8*i +: 8];
      x2    = xtime(a[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  function automatic logic [0:127] inv_mix_columns(input logic [0:127] s);
    logic [0:127] res;
    for (int c = 0; c < 4; c++)
      res[32*c +: 32] = inv_mix_col(s[32*c +: 32]);
    return res;
  endfunction

  state_e       state_q, state_d;
  logic [0:127] data_q, data_d;
  logic [0:127] key_q, key_d;
  logic [0:127] out_q, out_d;
  logic         init_q, init_d;
  logic         fin_q, fin_d;

  // NOTE: every signal gets its hold value before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    key_d   = key_q;
    out_d   = out_q;
    init_d  = init_q;
    fin_d   = fin_q;
    unique case (state_q)
      IDLE: begin
        if (bus.enableRounds && !(bus.initialRound && bus.finalRound)) begin
          data_d = bus.messageIn;
          key_d  = bus.newKey;
          init_d = bus.initialRound;
          fin_d  = bus.finalRound;
`ifdef INV_ROUNDS_FUSED_EN
          state_d = bus.initialRound ? ARK : ISB_SR;
`else
          state_d = bus.initialRound ? ARK : ISR;
`endif
        end
      end
`ifdef INV_ROUNDS_FUSED_EN
      ISB_SR: begin
        data_d  = inv_sub_bytes(inv_shift_rows(data_q));
        state_d = ARK;
      end
`else
      ISR: begin
        data_d  = inv_shift_rows(data_q);
        state_d = ISB;
      end
      ISB: begin
        data_d  = inv_sub_bytes(data_q);
        state_d = ARK;
      end
`endif
      ARK: begin
        data_d  = data_q ^ key_q;
        state_d = (init_q || fin_q) ? DONE : IMC;
      end
      IMC: begin
        data_d  = inv_mix_columns(data_q);
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Only the stage that completes the round publishes its result.
    if (state_d == DONE) out_d = data_d;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      key_q   <= '0;
      out_q   <= '0;
      init_q  <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      key_q   <= key_d;
      out_q   <= out_d;
      init_q  <= init_d;
      fin_q   <= fin_d;
    end
  end

  assign bus.messageOut = out_q;
  assign bus.roundsDone = (state_q == DONE);
  assign bus.busy       = (state_q != IDLE) && (state_q != DONE);

endmodule

// File: tb/tb_inv_rounds.sv
// Directed bench for inv_rounds using the FIPS-197 C.1 AES-128 inverse-cipher vectors.
module tb_inv_rounds;

`ifdef INV_ROUNDS_FUSED_EN
  localparam int LAT_MID = 3;
  localparam int LAT_FIN = 2;
`else
  localparam int LAT_MID = 4;
  localparam int LAT_FIN = 3;
`endif
  localparam int LAT_INI = 1;

  localparam logic [0:127] CT     = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [0:127] R1_IN  = 128'h7ad5fda789ef4e272bca100b3d9ff59f;
  localparam logic [0:127] R2_IN  = 128'h54d990a16ba09ab596bbf40ea111702f;
  localparam logic [0:127] R10_IN = 128'h6353e08c0960e104cd70b751bacad0e7;
  localparam logic [0:127] PT     = 128'h00112233445566778899aabbccddeeff;

  logic [0:127] rk [11];

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  inv_rounds_if bus ();

  inv_rounds dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic start_round(input logic ini, input logic fin, input logic [0:127] msg,
                             input logic [0:127] key, input bit scramble);
    @(negedge clk);
    bus.enableRounds = 1'b1;
    bus.initialRound = ini;
    bus.finalRound   = fin;
    bus.messageIn    = msg;
    bus.newKey       = key;
    @(negedge clk);
    bus.enableRounds = 1'b0;
    if (scramble) begin
      bus.messageIn    = {$urandom, $urandom, $urandom, $urandom};
      bus.newKey       = {$urandom, $urandom, $urandom, $urandom};
      bus.initialRound = ~ini;
      bus.finalRound   = ini;
    end
  endtask

  // Counts edges after the accepting edge until roundsDone; gives up after 20.
  task automatic wait_done(input int repulse_at, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      bus.enableRounds = (lat == repulse_at);
    end while (!bus.roundsDone && lat < 20);
    if (lat == repulse_at) @(negedge clk);
    bus.enableRounds = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.messageOut !== '0 || bus.busy !== 1'b0 || bus.roundsDone !== 1'b0) begin
      errors++;
      $display("FAIL reset: out=%h busy=%b done=%b expected 0/0/0", bus.messageOut, bus.busy, bus.roundsDone);
    end
    rst = 1'b0;
  endtask

  task automatic test_initial;
    int lat;
    start_round(1'b1, 1'b0, CT, rk[10], 1'b0);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL initial_busy: got %b expected 1", bus.busy);
    end
    wait_done(0, lat);
    checks++;
    if (lat != LAT_INI) begin
      errors++;
      $display("FAIL initial_latency: got %0d expected %0d", lat, LAT_INI);
    end
    checks++;
    if (bus.messageOut !== R1_IN) begin
      errors++;
      $display("FAIL initial_result: got %h expected %h", bus.messageOut, R1_IN);
    end
    @(negedge clk);
    checks++;
    if (bus.roundsDone !== 1'b0 || bus.messageOut !== R1_IN) begin
      errors++;
      $display("FAIL initial_pulse_hold: done=%b out=%h expected 0 and %h", bus.roundsDone, bus.messageOut, R1_IN);
    end
  endtask

  task automatic test_illegal_flags;
    @(negedge clk);
    bus.enableRounds = 1'b1;
    bus.initialRound = 1'b1;
    bus.finalRound   = 1'b1;
    bus.messageIn    = R2_IN;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.roundsDone !== 1'b0) begin
        errors++;
        $display("FAIL illegal_idle: busy=%b done=%b expected 0/0", bus.busy, bus.roundsDone);
      end
    end
    bus.enableRounds = 1'b0;
    checks++;
    if (bus.messageOut !== R1_IN) begin
      errors++;
      $display("FAIL illegal_out: got %h expected %h", bus.messageOut, R1_IN);
    end
  endtask

  task automatic test_middle_busy_start;
    int lat;
    int pulses;
    // Re-pulse mid-round, then re-pulse in the DONE cycle: both must be ignored.
    for (int k = 0; k < 2; k++) begin
      start_round(1'b0, 1'b0, R1_IN, rk[9], 1'b0);
      wait_done((k == 0) ? 2 : LAT_MID, lat);
      checks++;
      if (lat != LAT_MID) begin
        errors++;
        $display("FAIL middle_latency[%0d]: got %0d expected %0d", k, lat, LAT_MID);
      end
      checks++;
      if (bus.messageOut !== R2_IN) begin
        errors++;
        $display("FAIL middle_result[%0d]: got %h expected %h", k, bus.messageOut, R2_IN);
      end
      pulses = 0;
      repeat (6) begin
        @(negedge clk);
        if (bus.roundsDone === 1'b1 || bus.busy === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 0) begin
        errors++;
        $display("FAIL middle_extra_activity[%0d]: got %0d cycles expected 0", k, pulses);
      end
    end
  endtask

  task automatic test_final_input_change;
    int lat;
    start_round(1'b0, 1'b1, R10_IN, rk[0], 1'b1);
    wait_done(0, lat);
    checks++;
    if (lat != LAT_FIN) begin
      errors++;
      $display("FAIL final_latency: got %0d expected %0d", lat, LAT_FIN);
    end
    checks++;
    if (bus.messageOut !== PT) begin
      errors++;
      $display("FAIL final_result: got %h expected %h", bus.messageOut, PT);
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    int pulses;
    start_round(1'b0, 1'b0, R1_IN, rk[9], 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus.messageOut !== '0 || bus.busy !== 1'b0 || bus.roundsDone !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: out=%h busy=%b done=%b expected 0/0/0", bus.messageOut, bus.busy, bus.roundsDone);
    end
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.roundsDone === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL reset_mid_pulse: got %0d pulses expected 0", pulses);
    end
    start_round(1'b0, 1'b0, R1_IN, rk[9], 1'b0);
    wait_done(0, lat);
    checks++;
    if (lat != LAT_MID || bus.messageOut !== R2_IN) begin
      errors++;
      $display("FAIL reset_mid_rerun: lat=%0d out=%h expected %0d and %h", lat, bus.messageOut, LAT_MID, R2_IN);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    int bad_lat;
    logic [0:127] st;
    bad_lat = 0;
    start_round(1'b1, 1'b0, CT, rk[10], 1'b1);
    wait_done(0, lat);
    if (lat != LAT_INI) bad_lat++;
    st = bus.messageOut;
    checks++;
    if (st !== R1_IN) begin
      errors++;
      $display("FAIL chain_round10: got %h expected %h", st, R1_IN);
    end
    for (int r = 9; r >= 1; r--) begin
      start_round(1'b0, 1'b0, st, rk[r], 1'b1);
      wait_done(0, lat);
      if (lat != LAT_MID) bad_lat++;
      st = bus.messageOut;
    end
    start_round(1'b0, 1'b1, st, rk[0], 1'b1);
    wait_done(0, lat);
    if (lat != LAT_FIN) bad_lat++;
    checks++;
    if (bad_lat != 0) begin
      errors++;
      $display("FAIL chain_latency: got %0d wrong-latency rounds expected 0", bad_lat);
    end
    checks++;
    if (bus.messageOut !== PT) begin
      errors++;
      $display("FAIL chain_plaintext: got %h expected %h", bus.messageOut, PT);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rk[0]  = 128'h000102030405060708090a0b0c0d0e0f;
    rk[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    rk[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
    rk[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
    rk[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
    rk[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
    rk[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
    rk[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
    rk[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
    rk[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
    rk[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    rst              = 1'b1;
    bus.enableRounds = 1'b0;
    bus.initialRound = 1'b0;
    bus.finalRound   = 1'b0;
    bus.messageIn    = '0;
    bus.newKey       = '0;
    test_reset();
    test_initial();
    test_illegal_flags();
    test_middle_busy_start();
    test_final_input_change();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
